// File: rtl/pause_ctrl.sv
// pause_ctrl: merges external, user-toggle, OSD and frame-advance pause
// sources into a single CPU pause, and progressively dims the video
// while the core is held paused.
module pause_ctrl #(
  parameter int RW        = 8,
  parameter int GW        = 8,
  parameter int BW        = 8,
  parameter int CLKSPD    = 12,
  parameter int NREQ      = 4,
  parameter int DIM_MS    = 10000,
  parameter int FADE_MS   = 500,
  parameter int MAX_SHIFT = 3,
  localparam int LW       = $clog2(MAX_SHIFT + 1)
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            user_button,
  input  logic            step_button,
  input  logic [NREQ-1:0] pause_req,
  input  logic [NREQ-1:0] req_mask,
  input  logic [1:0]      options,
  input  logic            OSD_STATUS,
  input  logic            vblank,
  input  logic [RW-1:0]   r,
  input  logic [GW-1:0]   g,
  input  logic [BW-1:0]   b,
  output logic            pause_cpu,
  output logic [LW-1:0]   dim_level,
  output logic            stepping,
  output logic [RW-1:0]   r_out,
  output logic [GW-1:0]   g_out,
  output logic [BW-1:0]   b_out
);

  // Cycle counts are formed in 32-bit arithmetic; DIM_CYC must fit.
  localparam logic [31:0] DIM_CYC  = 32'(CLKSPD) * 32'd1000 * 32'(DIM_MS);
  localparam logic [31:0] FADE_CYC = 32'(CLKSPD) * 32'd1000 * 32'(FADE_MS);
  localparam logic [LW-1:0] MAX_LVL = LW'(MAX_SHIFT);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t        state_q;
  logic          user_prev_q;
  logic          step_prev_q;
  logic          vblank_prev_q;
  logic [31:0]   dim_cnt_q;
  logic [31:0]   dim_cnt_d;
  logic [LW-1:0] dim_level_q;
  logic [LW-1:0] dim_level_d;
  logic [RW-1:0] r_out_q;
  logic [GW-1:0] g_out_q;
  logic [BW-1:0] b_out_q;

  logic user_edge_s;
  logic step_edge_s;
  logic vblank_edge_s;
  logic user_hold_s;
  logic fade_en_s;

  assign user_edge_s   = user_button & ~user_prev_q;
  assign step_edge_s   = step_button & ~step_prev_q;
  assign vblank_edge_s = vblank & ~vblank_prev_q;
  assign user_hold_s   = (state_q == PAUSED);

  // STEP only drops the user component; any other active source keeps the CPU held.
  assign pause_cpu = ((|(pause_req & req_mask)) | user_hold_s | (OSD_STATUS & options[0])) & ~reset;
  assign fade_en_s = pause_cpu & options[1];

  // Edge-detect registers and the user pause / frame-advance state machine.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= RUN;
      user_prev_q   <= 1'b0;
      step_prev_q   <= 1'b0;
      vblank_prev_q <= 1'b0;
    end else begin
      user_prev_q   <= user_button;
      step_prev_q   <= step_button;
      // vblank history tracks every cycle, so a vblank rising in the
      // cycle STEP is entered is already history once STEP is active.
      vblank_prev_q <= vblank;
      case (state_q)
        RUN: begin
          if (user_edge_s) state_q <= PAUSED;
        end
        PAUSED: begin
          if (user_edge_s)      state_q <= RUN;
          else if (step_edge_s) state_q <= STEP;
        end
        STEP: begin
          if (user_edge_s)        state_q <= RUN;
          else if (vblank_edge_s) state_q <= PAUSED;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Dim timer next state: first step after DIM_CYC, then one per FADE_CYC, saturating.
  always_comb begin
    dim_cnt_d   = dim_cnt_q;
    dim_level_d = dim_level_q;
    if (!fade_en_s) begin
      dim_cnt_d   = 32'd0;
      dim_level_d = {LW{1'b0}};
    end else if (dim_level_q == {LW{1'b0}}) begin
      if (dim_cnt_q == DIM_CYC - 32'd1) begin
        dim_cnt_d   = 32'd0;
        dim_level_d = LW'(1);
      end else begin
        dim_cnt_d = dim_cnt_q + 32'd1;
      end
    end else if (dim_level_q < MAX_LVL) begin
      if (dim_cnt_q == FADE_CYC - 32'd1) begin
        dim_cnt_d   = 32'd0;
        dim_level_d = dim_level_q + LW'(1);
      end else begin
        dim_cnt_d = dim_cnt_q + 32'd1;
      end
    end else begin
      // Fully dimmed: timer holds so it can never wrap.
      dim_cnt_d = dim_cnt_q;
    end
  end

  // Dim timer and level registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dim_cnt_q   <= 32'd0;
      dim_level_q <= {LW{1'b0}};
    end else begin
      dim_cnt_q   <= dim_cnt_d;
      dim_level_q <= dim_level_d;
    end
  end

  // Video path: one-cycle registered right shift by the current dim level.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_out_q <= {RW{1'b0}};
      g_out_q <= {GW{1'b0}};
      b_out_q <= {BW{1'b0}};
    end else begin
      r_out_q <= r >> dim_level_q;
      g_out_q <= g >> dim_level_q;
      b_out_q <= b >> dim_level_q;
    end
  end

  assign dim_level = dim_level_q;
  assign stepping  = (state_q == STEP);
  assign r_out     = r_out_q;
  assign g_out     = g_out_q;
  assign b_out     = b_out_q;

endmodule

// File: tb/tb_pause_ctrl.sv
// Directed self-checking bench for pause_ctrl using short dim/fade timing.
module tb_pause_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       user_button;
  logic       step_button;
  logic [3:0] pause_req;
  logic [3:0] req_mask;
  logic [1:0] options;
  logic       OSD_STATUS;
  logic       vblank;
  logic [7:0] r, g, b;
  logic       pause_cpu;
  logic [1:0] dim_level;
  logic       stepping;
  logic [7:0] r_out, g_out, b_out;

  int checks   = 0;
  int failures = 0;

  pause_ctrl #(
    .RW(8), .GW(8), .BW(8), .CLKSPD(1), .NREQ(4),
    .DIM_MS(2), .FADE_MS(1), .MAX_SHIFT(3)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .user_button(user_button),
    .step_button(step_button),
    .pause_req  (pause_req),
    .req_mask   (req_mask),
    .options    (options),
    .OSD_STATUS (OSD_STATUS),
    .vblank     (vblank),
    .r          (r),
    .g          (g),
    .b          (b),
    .pause_cpu  (pause_cpu),
    .dim_level  (dim_level),
    .stepping   (stepping),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance n rising edges and land 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; user_button = 1'b0; step_button = 1'b0;
    pause_req = 4'b0000; req_mask = 4'b0000; options = 2'b00;
    OSD_STATUS = 1'b0; vblank = 1'b0; r = 8'hF0; g = 8'h0F; b = 8'hFF;
    tick(3);
    checks++; if (pause_cpu !== 1'b0) begin failures++; $display("FAIL rst_pause got=%0b exp=0", pause_cpu); end
    checks++; if (stepping !== 1'b0) begin failures++; $display("FAIL rst_stepping got=%0b exp=0", stepping); end
    checks++; if (dim_level !== 2'd0) begin failures++; $display("FAIL rst_dim got=%0d exp=0", dim_level); end
    checks++; if (r_out !== 8'h00 || g_out !== 8'h00 || b_out !== 8'h00) begin
      failures++; $display("FAIL rst_rgb got=%h/%h/%h exp=00/00/00", r_out, g_out, b_out); end
    reset = 1'b0;
    tick(1);
    checks++; if (r_out !== 8'hF0 || g_out !== 8'h0F || b_out !== 8'hFF) begin
      failures++; $display("FAIL run_rgb got=%h/%h/%h exp=f0/0f/ff", r_out, g_out, b_out); end
  endtask

  task automatic test_dim_fade();
    options = 2'b10;
    user_button = 1'b1;
    tick(1);
    user_button = 1'b0;
    checks++; if (pause_cpu !== 1'b1) begin failures++; $display("FAIL user_pause got=%0b exp=1", pause_cpu); end
    tick(1999);
    checks++; if (dim_level !== 2'd0) begin failures++; $display("FAIL dim_pre1 got=%0d exp=0", dim_level); end
    tick(1);
    checks++; if (dim_level !== 2'd1) begin failures++; $display("FAIL dim_lvl1 got=%0d exp=1", dim_level); end
    tick(1);
    checks++; if (r_out !== 8'h78 || g_out !== 8'h07 || b_out !== 8'h7F) begin
      failures++; $display("FAIL rgb_lvl1 got=%h/%h/%h exp=78/07/7f", r_out, g_out, b_out); end
    tick(998);
    checks++; if (dim_level !== 2'd1) begin failures++; $display("FAIL dim_pre2 got=%0d exp=1", dim_level); end
    tick(1);
    checks++; if (dim_level !== 2'd2) begin failures++; $display("FAIL dim_lvl2 got=%0d exp=2", dim_level); end
    tick(1);
    checks++; if (r_out !== 8'h3C) begin failures++; $display("FAIL r_lvl2 got=%h exp=3c", r_out); end
    tick(999);
    checks++; if (dim_level !== 2'd3) begin failures++; $display("FAIL dim_lvl3 got=%0d exp=3", dim_level); end
    tick(1);
    checks++; if (r_out !== 8'h1E) begin failures++; $display("FAIL r_lvl3 got=%h exp=1e", r_out); end
    tick(2000);
    checks++; if (dim_level !== 2'd3 || r_out !== 8'h1E) begin
      failures++; $display("FAIL dim_hold got=%0d/%h exp=3/1e", dim_level, r_out); end
    user_button = 1'b1;
    tick(1);
    user_button = 1'b0;
    checks++; if (pause_cpu !== 1'b0) begin failures++; $display("FAIL user_resume got=%0b exp=0", pause_cpu); end
    tick(2);
    checks++; if (dim_level !== 2'd0 || r_out !== 8'hF0) begin
      failures++; $display("FAIL undim got=%0d/%h exp=0/f0", dim_level, r_out); end
  endtask

  task automatic test_step();
    user_button = 1'b1; tick(1); user_button = 1'b0;
    step_button = 1'b1; tick(1); step_button = 1'b0;
    checks++; if (stepping !== 1'b1 || pause_cpu !== 1'b0) begin
      failures++; $display("FAIL step_enter got=%0b/%0b exp=1/0", stepping, pause_cpu); end
    tick(199);
    checks++; if (stepping !== 1'b1 || pause_cpu !== 1'b0) begin
      failures++; $display("FAIL step_wait got=%0b/%0b exp=1/0", stepping, pause_cpu); end
    vblank = 1'b1;
    tick(1);
    checks++; if (stepping !== 1'b0 || pause_cpu !== 1'b1 || dim_level !== 2'd0) begin
      failures++; $display("FAIL step_done got=%0b/%0b/%0d exp=0/1/0", stepping, pause_cpu, dim_level); end
    vblank = 1'b0;
    tick(1999);
    checks++; if (dim_level !== 2'd0) begin failures++; $display("FAIL restart_pre got=%0d exp=0", dim_level); end
    tick(1);
    checks++; if (dim_level !== 2'd1) begin failures++; $display("FAIL restart_lvl1 got=%0d exp=1", dim_level); end
    user_button = 1'b1; tick(1); user_button = 1'b0;
    tick(2);
  endtask

  task automatic test_mask();
    options = 2'b00;
    pause_req = 4'b0100; req_mask = 4'b0000;
    #1;
    checks++; if (pause_cpu !== 1'b0) begin failures++; $display("FAIL masked_req got=%0b exp=0", pause_cpu); end
    req_mask = 4'b0100;
    #1;
    checks++; if (pause_cpu !== 1'b1) begin failures++; $display("FAIL unmasked_req got=%0b exp=1", pause_cpu); end
    tick(1);
    user_button = 1'b1; tick(1); user_button = 1'b0;
    step_button = 1'b1; tick(1); step_button = 1'b0;
    checks++; if (stepping !== 1'b1 || pause_cpu !== 1'b1) begin
      failures++; $display("FAIL step_req got=%0b/%0b exp=1/1", stepping, pause_cpu); end
    tick(5);
    vblank = 1'b1;
    tick(1);
    checks++; if (stepping !== 1'b0 || pause_cpu !== 1'b1) begin
      failures++; $display("FAIL step_req_done got=%0b/%0b exp=0/1", stepping, pause_cpu); end
    vblank = 1'b0;
    user_button = 1'b1; tick(1); user_button = 1'b0;
    checks++; if (pause_cpu !== 1'b1) begin failures++; $display("FAIL req_hold got=%0b exp=1", pause_cpu); end
    pause_req = 4'b0000; req_mask = 4'b0000;
    #1;
    checks++; if (pause_cpu !== 1'b0) begin failures++; $display("FAIL req_clear got=%0b exp=0", pause_cpu); end
  endtask

  task automatic test_osd();
    OSD_STATUS = 1'b1; options = 2'b01;
    #1;
    checks++; if (pause_cpu !== 1'b1) begin failures++; $display("FAIL osd_pause got=%0b exp=1", pause_cpu); end
    options = 2'b00;
    #1;
    checks++; if (pause_cpu !== 1'b0) begin failures++; $display("FAIL osd_off got=%0b exp=0", pause_cpu); end
    options = 2'b01;
    tick(10000);
    checks++; if (pause_cpu !== 1'b1 || dim_level !== 2'd0) begin
      failures++; $display("FAIL osd_nodim got=%0b/%0d exp=1/0", pause_cpu, dim_level); end
    OSD_STATUS = 1'b0;
    options = 2'b10;
    tick(2);
  endtask

  task automatic test_same_cycle();
    user_button = 1'b1;
    tick(5);
    checks++; if (pause_cpu !== 1'b1) begin failures++; $display("FAIL held_user got=%0b exp=1", pause_cpu); end
    user_button = 1'b0; tick(1);
    user_button = 1'b1; step_button = 1'b1;
    tick(1);
    user_button = 1'b0; step_button = 1'b0;
    checks++; if (stepping !== 1'b0 || pause_cpu !== 1'b0) begin
      failures++; $display("FAIL user_wins got=%0b/%0b exp=0/0", stepping, pause_cpu); end
    step_button = 1'b1; tick(1); step_button = 1'b0;
    tick(1);
    checks++; if (stepping !== 1'b0 || pause_cpu !== 1'b0) begin
      failures++; $display("FAIL run_step_ignored got=%0b/%0b exp=0/0", stepping, pause_cpu); end
    tick(2);
  endtask

  task automatic test_reset_mid();
    options = 2'b10; r = 8'hF0;
    pause_req = 4'b0100; req_mask = 4'b0100;
    user_button = 1'b1; tick(1); user_button = 1'b0;
    step_button = 1'b1; tick(1); step_button = 1'b0;
    tick(3200);
    checks++; if (stepping !== 1'b1 || dim_level !== 2'd2 || r_out !== 8'h3C) begin
      failures++; $display("FAIL pre_reset got=%0b/%0d/%h exp=1/2/3c", stepping, dim_level, r_out); end
    reset = 1'b1;
    #1;
    checks++; if (pause_cpu !== 1'b0) begin failures++; $display("FAIL reset_pause got=%0b exp=0", pause_cpu); end
    tick(1);
    checks++; if (stepping !== 1'b0 || dim_level !== 2'd0 || r_out !== 8'h00) begin
      failures++; $display("FAIL reset_state got=%0b/%0d/%h exp=0/0/00", stepping, dim_level, r_out); end
    reset = 1'b0;
    #1;
    checks++; if (pause_cpu !== 1'b1) begin failures++; $display("FAIL req_reassert got=%0b exp=1", pause_cpu); end
    r = 8'h5A;
    tick(1);
    checks++; if (r_out !== 8'h5A) begin failures++; $display("FAIL track_5a got=%h exp=5a", r_out); end
    r = 8'hA5;
    tick(1);
    checks++; if (r_out !== 8'hA5 || stepping !== 1'b0) begin
      failures++; $display("FAIL track_a5 got=%h/%0b exp=a5/0", r_out, stepping); end
  endtask

  initial begin
    test_reset();
    test_dim_fade();
    test_step();
    test_mask();
    test_osd();
    test_same_cycle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
